// File: rtl/vga_pkg.sv
// Shared video constants, button indices and the cursor clamp helper.
package vga_pkg;

    localparam int unsigned SCREEN_W = 256;
    localparam int unsigned SCREEN_H = 240;
    localparam int unsigned POS_W    = 9;
    localparam int unsigned COORD_W  = 10;
    localparam int unsigned NUM_BTN  = 5;

    localparam logic [2:0] COLOR_BLACK   = 3'b000;
    localparam logic [2:0] COLOR_RED     = 3'b001;
    localparam logic [2:0] COLOR_GREEN   = 3'b010;
    localparam logic [2:0] COLOR_YELLOW  = 3'b011;
    localparam logic [2:0] COLOR_BLUE    = 3'b100;
    localparam logic [2:0] COLOR_MAGENTA = 3'b101;
    localparam logic [2:0] COLOR_CYAN    = 3'b110;
    localparam logic [2:0] COLOR_WHITE   = 3'b111;

    typedef enum logic [2:0] {
        BTN_LEFT  = 3'd0,
        BTN_RIGHT = 3'd1,
        BTN_UP    = 3'd2,
        BTN_DOWN  = 3'd3,
        BTN_SPACE = 3'd4
    } btn_idx_e;

    // One saturating step along an axis; opposing directions cancel. Signed
    // 10-bit math keeps pos-step from wrapping below zero.
    function automatic logic [POS_W-1:0] step_clamp(
        input logic [POS_W-1:0] pos,
        input logic             dec,
        input logic             inc,
        input logic [POS_W-1:0] step,
        input logic [POS_W-1:0] lo,
        input logic [POS_W-1:0] hi
    );
        logic signed [COORD_W-1:0] cur;
        logic signed [COORD_W-1:0] stp;
        logic signed [COORD_W-1:0] lo_e;
        logic signed [COORD_W-1:0] hi_e;
        logic signed [COORD_W-1:0] nxt;
        cur  = {1'b0, pos};
        stp  = {1'b0, step};
        lo_e = {1'b0, lo};
        hi_e = {1'b0, hi};
        nxt  = cur;
        if (dec && !inc) begin
            nxt = cur - stp;
            if (nxt < lo_e) nxt = lo_e;
        end else if (inc && !dec) begin
            nxt = cur + stp;
            if (nxt > hi_e) nxt = hi_e;
        end
        return nxt[POS_W-1:0];
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus frame-strobed debounce counter for one button.
module button_debounce #(
    parameter int unsigned DEBOUNCE_FRAMES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic strobe,
    output logic level
);

    localparam int unsigned CNT_W = (DEBOUNCE_FRAMES > 1) ? $clog2(DEBOUNCE_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_FRAMES - 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             level_next;

    // Level flips once the mismatch has been seen on DEBOUNCE_FRAMES strobes in a row.
    always_comb begin
        cnt_next   = cnt;
        level_next = level;
        if (strobe) begin
            if (sync_2 != level) begin
                if (cnt == CNT_LAST) begin
                    level_next = ~level;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end else begin
                cnt_next = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
            cnt    <= '0;
            level  <= 1'b0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
            cnt    <= cnt_next;
            level  <= level_next;
        end
    end

endmodule

// File: rtl/cursor_controller.sv
// Player-2 cursor: debounced buttons drive a clamped, auto-repeating (x,y)
// position and a select toggle, all updated once per frame strobe.
module cursor_controller
    import vga_pkg::*;
#(
    parameter int unsigned INIT_X          = 64,
    parameter int unsigned INIT_Y          = 30,
    parameter int unsigned X_MIN           = 2,
    parameter int unsigned X_MAX           = 220,
    parameter int unsigned Y_MIN           = 2,
    parameter int unsigned Y_MAX           = 200,
    parameter int unsigned STEP            = 1,
    parameter int unsigned DEBOUNCE_FRAMES = 2,
    parameter int unsigned REPEAT_DELAY    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               vsync,
    input  logic [NUM_BTN-1:0] btn,
    output logic [POS_W-1:0]   pos_x,
    output logic [POS_W-1:0]   pos_y,
    output logic               selected,
    output logic               fire_pulse,
    output logic               moving
);

    localparam int unsigned HOLD_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(REPEAT_DELAY);
    localparam logic [POS_W-1:0]  STEP_V   = POS_W'(STEP);
    localparam logic [POS_W-1:0]  X_MIN_V  = POS_W'(X_MIN);
    localparam logic [POS_W-1:0]  X_MAX_V  = POS_W'(X_MAX);
    localparam logic [POS_W-1:0]  Y_MIN_V  = POS_W'(Y_MIN);
    localparam logic [POS_W-1:0]  Y_MAX_V  = POS_W'(Y_MAX);

    logic               vsync_q;
    logic               strobe_c;
    logic [NUM_BTN-1:0] db;
    logic               any_dir_c;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [HOLD_W-1:0]  hold_next;
    logic               space_prev;
    logic               space_prev_next;
    logic [POS_W-1:0]   pos_x_next;
    logic [POS_W-1:0]   pos_y_next;
    logic               selected_next;
    logic               fire_next;

    assign strobe_c  = vsync & ~vsync_q;
    assign any_dir_c = db[BTN_LEFT] | db[BTN_RIGHT] | db[BTN_UP] | db[BTN_DOWN];

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .raw   (btn[i]),
            .strobe(strobe_c),
            .level (db[i])
        );
    end

    // db holds the pre-strobe debounced state here, giving one frame of latency.
    always_comb begin
        pos_x_next      = pos_x;
        pos_y_next      = pos_y;
        hold_next       = hold_cnt;
        selected_next   = selected;
        fire_next       = 1'b0;
        space_prev_next = space_prev;
        if (strobe_c) begin
            space_prev_next = db[BTN_SPACE];
            if (db[BTN_SPACE] && !space_prev) begin
                fire_next     = 1'b1;
                selected_next = ~selected;
            end
            if (any_dir_c) begin
                if (hold_cnt == '0 || hold_cnt == HOLD_MAX) begin
                    pos_x_next = step_clamp(pos_x, db[BTN_LEFT], db[BTN_RIGHT],
                                            STEP_V, X_MIN_V, X_MAX_V);
                    pos_y_next = step_clamp(pos_y, db[BTN_UP], db[BTN_DOWN],
                                            STEP_V, Y_MIN_V, Y_MAX_V);
                end
                if (hold_cnt != HOLD_MAX) hold_next = hold_cnt + HOLD_W'(1);
            end else begin
                hold_next = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vsync_q    <= 1'b0;
            pos_x      <= POS_W'(INIT_X);
            pos_y      <= POS_W'(INIT_Y);
            hold_cnt   <= '0;
            selected   <= 1'b0;
            fire_pulse <= 1'b0;
            space_prev <= 1'b0;
            moving     <= 1'b0;
        end else begin
            vsync_q    <= vsync;
            pos_x      <= pos_x_next;
            pos_y      <= pos_y_next;
            hold_cnt   <= hold_next;
            selected   <= selected_next;
            fire_pulse <= fire_next;
            space_prev <= space_prev_next;
            moving     <= any_dir_c;
        end
    end

endmodule

// File: tb/tb_cursor_controller.sv
// Directed frame-by-frame vectors for cursor_controller plus a reset-mid-hold sequence.
module tb_cursor_controller;

    localparam logic [4:0] B_NONE = 5'b00000;
    localparam logic [4:0] B_L    = 5'b00001;
    localparam logic [4:0] B_R    = 5'b00010;
    localparam logic [4:0] B_U    = 5'b00100;
    localparam logic [4:0] B_S    = 5'b10000;

    logic       clk;
    logic       reset;
    logic       vsync;
    logic [4:0] btn;
    logic [8:0] pos_x;
    logic [8:0] pos_y;
    logic       selected;
    logic       fire_pulse;
    logic       moving;

    cursor_controller dut (
        .clk       (clk),
        .reset     (reset),
        .vsync     (vsync),
        .btn       (btn),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .selected  (selected),
        .fire_pulse(fire_pulse),
        .moving    (moving)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  btn;
        logic [15:0] frames;
        logic [8:0]  x;
        logic [8:0]  y;
        logic        sel;
        logic        mov;
        logic [3:0]  fires;
    } vec_t;

    vec_t vecs[80];
    int   nvec;
    int   checks;
    int   passes;
    int   fire_cnt;

    always @(negedge clk) if (fire_pulse === 1'b1) fire_cnt++;

    task automatic add(input logic [4:0] b, input int f, input int x, input int y,
                       input logic s, input logic m, input int fc);
        vecs[nvec] = '{b, 16'(f), 9'(x), 9'(y), s, m, 4'(fc)};
        nvec++;
    endtask

    task automatic chk(input string what, input int idx, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s step%0d: got %0d expected %0d", what, idx, act, exp);
    endtask

    task automatic chk_all(input int idx, input int x, input int y, input int s,
                           input int m, input int fc);
        chk("pos_x", idx, int'(pos_x), x);
        chk("pos_y", idx, int'(pos_y), y);
        chk("selected", idx, int'(selected), s);
        chk("moving", idx, int'(moving), m);
        chk("fire_pulses", idx, fire_cnt, fc);
    endtask

    // 64-clk frame with the vsync pulse at its end; returns 2 clks after the strobe.
    task automatic do_frame();
        repeat (62) @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        nvec = 0; checks = 0; passes = 0; fire_cnt = 0;
        reset = 1'b0; vsync = 1'b0; btn = B_NONE;

        // idle, then a single-frame glitch that must be rejected
        add(B_NONE, 10, 64, 30, 0, 0, 0);
        add(B_R, 1, 64, 30, 0, 0, 0);
        add(B_NONE, 20, 64, 30, 0, 0, 0);
        // right held: debounce, first move, repeat delay, repeat; release lag
        add(B_R, 2, 64, 30, 0, 1, 0);
        add(B_R, 1, 65, 30, 0, 1, 0);
        add(B_R, 7, 65, 30, 0, 1, 0);
        add(B_R, 1, 66, 30, 0, 1, 0);
        add(B_R, 3, 69, 30, 0, 1, 0);
        add(B_NONE, 2, 71, 30, 0, 0, 0);
        add(B_NONE, 2, 71, 30, 0, 0, 0);
        // left+right+up: x cancels, y moves
        add(B_L | B_R | B_U, 2, 71, 30, 0, 1, 0);
        add(B_L | B_R | B_U, 1, 71, 29, 0, 1, 0);
        add(B_L | B_R | B_U, 7, 71, 29, 0, 1, 0);
        add(B_L | B_R | B_U, 1, 71, 28, 0, 1, 0);
        add(B_L | B_R | B_U, 2, 71, 26, 0, 1, 0);
        add(B_NONE, 3, 71, 24, 0, 0, 0);
        // diagonal up+right
        add(B_U | B_R, 2, 71, 24, 0, 1, 0);
        add(B_U | B_R, 1, 72, 23, 0, 1, 0);
        add(B_U | B_R, 7, 72, 23, 0, 1, 0);
        add(B_U | B_R, 1, 73, 22, 0, 1, 0);
        add(B_NONE, 3, 75, 20, 0, 0, 0);
        // left clamp at X_MIN
        add(B_L, 2, 75, 20, 0, 1, 0);
        add(B_L, 1, 74, 20, 0, 1, 0);
        add(B_L, 7, 74, 20, 0, 1, 0);
        add(B_L, 1, 73, 20, 0, 1, 0);
        add(B_L, 69, 4, 20, 0, 1, 0);
        add(B_L, 1, 3, 20, 0, 1, 0);
        add(B_L, 1, 2, 20, 0, 1, 0);
        add(B_L, 5, 2, 20, 0, 1, 0);
        add(B_NONE, 3, 2, 20, 0, 0, 0);
        // up clamp at Y_MIN
        add(B_U, 2, 2, 20, 0, 1, 0);
        add(B_U, 1, 2, 19, 0, 1, 0);
        add(B_U, 7, 2, 19, 0, 1, 0);
        add(B_U, 1, 2, 18, 0, 1, 0);
        add(B_U, 15, 2, 3, 0, 1, 0);
        add(B_U, 1, 2, 2, 0, 1, 0);
        add(B_U, 5, 2, 2, 0, 1, 0);
        add(B_NONE, 3, 2, 2, 0, 0, 0);
        // right clamp at X_MAX
        add(B_R, 2, 2, 2, 0, 1, 0);
        add(B_R, 1, 3, 2, 0, 1, 0);
        add(B_R, 7, 3, 2, 0, 1, 0);
        add(B_R, 1, 4, 2, 0, 1, 0);
        add(B_R, 215, 219, 2, 0, 1, 0);
        add(B_R, 1, 220, 2, 0, 1, 0);
        add(B_R, 5, 220, 2, 0, 1, 0);
        add(B_NONE, 3, 220, 2, 0, 0, 0);
        // space: one toggle per press, held never retoggles
        add(B_S, 2, 220, 2, 0, 0, 0);
        add(B_S, 1, 220, 2, 1, 0, 1);
        add(B_S, 27, 220, 2, 1, 0, 0);
        add(B_NONE, 3, 220, 2, 1, 0, 0);
        add(B_S, 3, 220, 2, 0, 0, 1);
        add(B_NONE, 3, 220, 2, 0, 0, 0);

        repeat (4) @(negedge clk);
        chk_all(0, 64, 30, 0, 0, 0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < nvec; i++) begin
            btn      = vecs[i].btn;
            fire_cnt = 0;
            repeat (int'(vecs[i].frames)) do_frame();
            chk_all(i + 1, int'(vecs[i].x), int'(vecs[i].y), int'(vecs[i].sel),
                    int'(vecs[i].mov), int'(vecs[i].fires));
        end

        // reset in the middle of a left+space hold; must re-debounce afterwards
        btn = B_L | B_S;
        fire_cnt = 0;
        repeat (3) do_frame();
        chk_all(100, 219, 2, 1, 1, 1);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #1;
        chk_all(101, 64, 30, 0, 0, 1);
        chk("fire_in_reset", 101, int'(fire_pulse), 0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        fire_cnt = 0;
        repeat (2) do_frame();
        chk_all(102, 64, 30, 0, 1, 0);
        do_frame();
        chk_all(103, 63, 30, 1, 1, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
